// File: rtl/instr_fetch_unit.sv
// Fetch stage: requests instruction words over req/ack, holds them in the IR for the CU,
// and picks the next PC from the CU's Jump/Branch decision when the instruction is consumed.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              Imem_Req,
    output logic [ADDR_W-1:0] Imem_Addr,
    input  logic              Imem_Ack,
    input  logic [31:0]       Imem_Rdata,
    output logic [31:0]       Instr,
    output logic [3:0]        Opcode,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              Branch_Taken,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       Instr_Count
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue} stateE;

    stateE             state;
    logic [ADDR_W-1:0] pcQ;
    logic [31:0]       irQ;
    logic              reqQ;
    logic              validQ;
    logic [31:0]       countQ;

    logic [ADDR_W-1:0] branchOff;
    logic [ADDR_W-1:0] seqPc;
    logic [ADDR_W-1:0] nextPc;

    // The 16-bit offset is sign-extended to the PC width (or simply truncated if narrower).
    if (ADDR_W <= 16) begin : gOffNarrow
        assign branchOff = irQ[ADDR_W-1:0];
    end else begin : gOffWide
        assign branchOff = {{(ADDR_W - 16){irQ[15]}}, irQ[15:0]};
    end

    always_comb begin
        seqPc  = pcQ + ADDR_W'(1);
        nextPc = seqPc;
        if (Jump) begin
            nextPc = irQ[ADDR_W-1:0];
        end else if (Branch && Branch_Taken) begin
            nextPc = seqPc + branchOff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            pcQ    <= RESET_PC;
            irQ    <= '0;
            reqQ   <= 1'b0;
            validQ <= 1'b0;
            countQ <= '0;
        end else begin
            case (state)
                StIdle: begin
                    state <= StFetch;
                    reqQ  <= 1'b1;
                end
                StFetch: begin
                    if (Imem_Ack) begin
                        irQ    <= Imem_Rdata;
                        reqQ   <= 1'b0;
                        validQ <= 1'b1;
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    if (Instr_Ready) begin
                        pcQ    <= nextPc;
                        countQ <= countQ + 32'd1;
                        validQ <= 1'b0;
                        reqQ   <= 1'b1;
                        state  <= StFetch;
                    end
                end
                default: begin
                    state  <= StIdle;
                    reqQ   <= 1'b0;
                    validQ <= 1'b0;
                end
            endcase
        end
    end

    assign Imem_Req    = reqQ;
    assign Imem_Addr   = pcQ;
    assign Instr       = irQ;
    assign Opcode      = irQ[31:28];
    assign Instr_Valid = validQ;
    assign PC          = pcQ;
    assign Instr_Count = countQ;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a reference model predicts every issued instruction
// and a monitor compares the DUT against the predicted queue each cycle.
module tb_instr_fetch_unit;

    localparam int unsigned AW   = 8;
    localparam int unsigned MASK = (1 << AW) - 1;

    typedef struct {
        int unsigned pc;
        logic [31:0] instr;
        logic [31:0] count;
    } expT;

    logic          clk = 1'b0;
    logic          reset;
    logic          Imem_Req;
    logic [AW-1:0] Imem_Addr;
    logic          Imem_Ack;
    logic [31:0]   Imem_Rdata;
    logic [31:0]   Instr;
    logic [3:0]    Opcode;
    logic          Instr_Valid;
    logic          Instr_Ready;
    logic          Jump;
    logic          Branch;
    logic          Branch_Taken;
    logic [AW-1:0] PC;
    logic [31:0]   Instr_Count;

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .Imem_Req     (Imem_Req),
        .Imem_Addr    (Imem_Addr),
        .Imem_Ack     (Imem_Ack),
        .Imem_Rdata   (Imem_Rdata),
        .Instr        (Instr),
        .Opcode       (Opcode),
        .Instr_Valid  (Instr_Valid),
        .Instr_Ready  (Instr_Ready),
        .Jump         (Jump),
        .Branch       (Branch),
        .Branch_Taken (Branch_Taken),
        .PC           (PC),
        .Instr_Count  (Instr_Count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    expT         expQ[$];
    logic [2:0]  dirCtrl[$];
    int          nChecks = 0;
    int          nPass   = 0;
    int          nIssued = 0;
    int          modelPc;
    int          modelCount;
    int          reqCycles;
    int          lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference next-PC rule with plain integer arithmetic.
    task automatic modelConsume(input logic j, input logic b, input logic t);
        int unsigned ins;
        int          off;
        int          np;
        expT         e;
        ins = mem[modelPc];
        off = int'($signed(ins[15:0]));
        if (j) np = int'(ins & MASK);
        else if (b && t) np = (modelPc + 1 + off) & int'(MASK);
        else np = (modelPc + 1) & int'(MASK);
        modelPc    = np;
        modelCount = modelCount + 1;
        e.pc    = int'(np);
        e.instr = mem[np];
        e.count = 32'(modelCount);
        expQ.push_back(e);
    endtask

    task automatic doReset(input logic lateAck);
        expT e;
        reset       = 1'b1;
        Imem_Ack    = 1'b1;
        Imem_Rdata  = $urandom;
        Instr_Ready = 1'b1;
        Jump        = 1'b1;
        @(posedge clk);
        #1;
        check("reset_req", 32'(Imem_Req), 32'd0);
        check("reset_valid", 32'(Instr_Valid), 32'd0);
        check("reset_pc", 32'(PC), 32'd0);
        check("reset_count", Instr_Count, 32'd0);
        check("reset_ir", Instr, 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        Imem_Ack     = lateAck;
        Imem_Rdata   = $urandom;
        Instr_Ready  = 1'($urandom);
        Jump         = 1'($urandom);
        Branch       = 1'($urandom);
        Branch_Taken = 1'($urandom);
        expQ.delete();
        modelPc    = 0;
        modelCount = 0;
        e.pc    = 0;
        e.instr = mem[0];
        e.count = 32'd0;
        expQ.push_back(e);
        reqCycles = 0;
        lat       = $urandom_range(0, 4);
    endtask

    task automatic driveCycle();
        logic [2:0] c;
        if (Imem_Req) begin
            if (reqCycles >= lat) begin
                Imem_Ack   = 1'b1;
                Imem_Rdata = mem[Imem_Addr];
            end else begin
                Imem_Ack   = 1'b0;
                Imem_Rdata = $urandom;
            end
            reqCycles++;
        end else begin
            reqCycles  = 0;
            lat        = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            Imem_Ack   = ($urandom_range(0, 7) == 0);
            Imem_Rdata = $urandom;
        end
        Instr_Ready = Instr_Valid ? ($urandom_range(0, 2) != 0) : 1'($urandom);
        c = {($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 1'($urandom)};
        if (Instr_Valid && Instr_Ready && dirCtrl.size() > 0) c = dirCtrl.pop_front();
        Jump         = c[2];
        Branch       = c[1];
        Branch_Taken = c[0];
        if (Instr_Valid && Instr_Ready) modelConsume(c[2], c[1], c[0]);
    endtask

    // Monitor: compares DUT outputs against the scoreboard each cycle.
    initial begin
        logic rstAtEdge;
        logic haveCur;
        expT  cur;
        haveCur = 1'b0;
        forever begin
            @(posedge clk);
            rstAtEdge = reset;
            #1;
            if (rstAtEdge) begin
                haveCur = 1'b0;
            end else if (Instr_Valid) begin
                if (Imem_Req) check("req_valid_exclusive", 32'(Imem_Req), 32'd0);
                if (!haveCur) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        $display("FAIL unexpected_issue: PC %h issued with no prediction", PC);
                    end else begin
                        cur     = expQ.pop_front();
                        haveCur = 1'b1;
                        nIssued++;
                    end
                end
                if (haveCur) begin
                    check("issue_pc", 32'(PC), cur.pc);
                    check("issue_instr", Instr, cur.instr);
                    check("issue_opcode", 32'(Opcode), 32'(cur.instr[31:28]));
                    check("issue_count", Instr_Count, cur.count);
                end
            end else begin
                haveCur = 1'b0;
                if (Imem_Req) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        $display("FAIL unexpected_fetch: addr %h fetched with no prediction",
                                 Imem_Addr);
                    end else begin
                        check("fetch_addr", 32'(Imem_Addr), expQ[0].pc);
                        check("fetch_count", Instr_Count, expQ[0].count);
                    end
                end
            end
        end
    end

    // Driver: memory responder, consumer and reference model.
    initial begin
        int idleRun;
        int rstMode;
        int rstWait;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h00] = 32'hF000_0040;
        mem[8'h40] = 32'hF000_0010;
        mem[8'h10] = 32'h1000_FFFC;
        mem[8'h0D] = 32'h3000_0005;
        mem[8'h0E] = 32'hF000_00FF;
        // {Jump, Branch, Taken}: jump, jump, taken branch, untaken branch, jump+branch, sequential
        dirCtrl = '{3'b100, 3'b100, 3'b011, 3'b010, 3'b111, 3'b000};
        reset        = 1'b1;
        Imem_Ack     = 1'b0;
        Imem_Rdata   = '0;
        Instr_Ready  = 1'b0;
        Jump         = 1'b0;
        Branch       = 1'b0;
        Branch_Taken = 1'b0;
        idleRun = 0;
        rstMode = 0;
        rstWait = 0;
        repeat (2) @(negedge clk);
        doReset(1'b0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (Instr_Valid) idleRun = 0;
            else idleRun++;
            if (idleRun > 12) begin
                nChecks++;
                $display("FAIL progress: Instr_Valid low for %0d cycles, expected at most 12",
                         idleRun);
                idleRun = 0;
            end
            if (cyc == 400) rstMode = 1;
            if (cyc == 800) rstMode = 2;
            if (rstMode != 0) begin
                rstWait++;
                if ((rstMode == 1 && Imem_Req) || (rstMode == 2 && Instr_Valid)) begin
                    doReset(1'b1);
                    rstMode = 0;
                    rstWait = 0;
                    idleRun = 0;
                    continue;
                end else if (rstWait > 50) begin
                    nChecks++;
                    $display("FAIL reset_target: state for reset mode %0d not seen in 50 cycles",
                             rstMode);
                    rstMode = 0;
                    rstWait = 0;
                end
            end
            driveCycle();
        end
        check("issued_enough", 32'(nIssued > 100), 32'd1);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
